sw_event_encoder: RTL
=====================

Name: sw_event_encoder

Overview:
- Sits directly downstream of the toggle-switch debouncer and consumes its debounced switch vector.
- Detects every level change on any switch and encodes it as a discrete event {switch index, new level}.
- Buffers events in a small FIFO and hands them to the control logic over a valid/ready interface.
- Simultaneous changes on several switches are serialised, lowest index first, and no change is lost while the FIFO is full.

Parameters:
- no_of_switches, 9: width of the debounced switch vector.
- fifo_depth, 4: event FIFO entries; must be a power of 2, minimum 2.
- IDX_W (localparam): clog2(no_of_switches), minimum 1; width of the event index.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sw_in  in  no_of_switches  debounced switch levels, already synchronous to clock.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head event.
- evt_index  out  IDX_W  switch index of the head event.
- evt_level  out  1  switch level carried by the head event.
- fifo_count  out  clog2(fifo_depth)+1  number of events currently queued.
- overflow  out  1  sticky flag: a change was coalesced into an already-pending bit.

Behaviour:
- Reset (synchronous, active-high). The following are all cleared:
  - the FIFO, with evt_valid=0, evt_index=0, evt_level=0, fifo_count=0;
  - the pending mask, set to 0;
  - overflow, set to 0;
  - the primed flag and sw_prev, set to 0.
- A reset asserted mid-operation discards all queued and pending events.
- First cycle after reset (primed=0):
  - sw_prev<=sw_in and primed<=1;
  - no events are generated, so the initial switch positions never appear as changes.
- When primed:
  - change = sw_in ^ sw_prev, computed every cycle;
  - sw_prev<=sw_in;
  - pending <= (pending & ~served) | change.
- Set wins: if bit i is served and changes again in the same cycle, pending[i] stays 1.
- Coalescing: if change[i]=1 while pending[i]=1 and bit i is not served that cycle, overflow<=1 (sticky until reset).
- Serving (combinational selection, registered push):
  - when pending!=0 and the FIFO is not full, select the lowest set index i;
  - push {i, sw_prev[i]} and mark i as served;
  - the level pushed is the most recent registered level, not the level at the time of the change;
  - at most one push per cycle.
- FIFO full: no push occurs; pending holds all outstanding changes, so nothing is lost except coalesced toggles.
- FIFO is first-word-fall-through:
  - evt_valid = (fifo_count!=0);
  - evt_index and evt_level are valid whenever evt_valid=1 and stay stable until popped;
  - pop happens when evt_valid && evt_ready;
  - evt_ready while evt_valid=0 is ignored.
- Simultaneous push and pop:
  - allowed when not full; fifo_count is unchanged;
  - full is decided from the registered count, so no push occurs in the cycle a full FIFO is popped.
- Pointers wrap modulo fifo_depth; fifo_count saturates at exactly fifo_depth by construction.
- Latency, for a change on sw_in visible before edge E with an empty FIFO and no other pending bits:
  - pending is set at E;
  - the event is pushed at E+1;
  - evt_valid=1 after E+1, i.e. 2 cycles.

Optional Feature:
- Macro: SW_EVENT_DROP_CNT_EN.
- Defined:
  - adds output port drop_count, 8 bits, reset 0;
  - increments on every coalescing event (same condition that sets overflow) and saturates at 255.
- Undefined: the port and counter do not exist; overflow behaviour is unchanged.

Decomposition:
- Package sw_event_pkg holds:
  - the event record layout: EVT_W = IDX_W+1, with level in bit 0 and index above it;
  - the drop_count width constant, 8.
- Sub-module sw_event_fifo:
  - parameterised by width and depth;
  - FWFT;
  - provides push, full, pop, empty and count;
  - instantiated once.
- Change detection, pending mask and priority select stay in the top module.

Test Plan:
1. Release reset with sw_in=9'h1A5, hold it for 20 cycles -> evt_valid stays 0 and fifo_count stays 0; initial levels are not reported.
2. Primed, toggle sw_in[3] 0->1 with evt_ready=1 -> evt_valid rises 2 cycles later with evt_index=3, evt_level=1, and is popped the same cycle.
3. Change bits 7, 2 and 5 in the same cycle with evt_ready=0 -> FIFO holds indices 2, 5, 7 in that order with correct levels; fifo_count=3.
4. Hold evt_ready=0 and change 6 distinct bits with fifo_depth=4 -> fifo_count=4 and the 2 highest indices remain pending. Then raise evt_ready -> all 6 events emerge in index order and overflow=0.
5. With the FIFO full and pending[1]=1, toggle sw_in[1] twice -> overflow=1, bit 1 yields exactly one event with the final level, and drop_count=2 when SW_EVENT_DROP_CNT_EN is defined.
6. Assert reset for 1 cycle with 3 events queued and 2 pending -> evt_valid=0, fifo_count=0, overflow=0; the next post-reset cycle re-primes without emitting events.

Source files
------------

// File: rtl/sw_event_pkg.sv
// Shared constants for the switch event encoder: event record layout and drop counter width.
package sw_event_pkg;

  localparam int unsigned DROP_CNT_W    = 8;
  localparam int unsigned EVT_LEVEL_BIT = 0;
  localparam int unsigned EVT_INDEX_LSB = 1;

  // Index width for n switches, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Event record: level in bit 0, index above it.
  function automatic int unsigned evt_width(input int unsigned idx_w);
    return idx_w + 1;
  endfunction

endpackage

// File: rtl/sw_event_fifo.sv
// First-word-fall-through FIFO with registered occupancy count; depth must be a power of 2.
module sw_event_fifo #(
  parameter int unsigned width = 5,
  parameter int unsigned depth = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [width-1:0]       push_data,
  output logic                   full,
  input  logic                   pop,
  output logic [width-1:0]       pop_data,
  output logic                   empty,
  output logic [$clog2(depth):0] count
);

  localparam int unsigned PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned CNT_W = $clog2(depth) + 1;

  logic [width-1:0] mem [depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(depth));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  // Head is forced to zero while empty so stale storage never shows on the outputs.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sw_event_encoder.sv
// Turns debounced switch level changes into {index, level} events queued in a FWFT FIFO.
// Optional macro SW_EVENT_DROP_CNT_EN adds a saturating drop_count output.
module sw_event_encoder
  import sw_event_pkg::*;
#(
  parameter int unsigned no_of_switches = 9,
  parameter int unsigned fifo_depth     = 4,
  localparam int unsigned IDX_W         = idx_width(no_of_switches),
  localparam int unsigned CNT_W         = $clog2(fifo_depth) + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [no_of_switches-1:0] sw_in,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [IDX_W-1:0]          evt_index,
  output logic                      evt_level,
  output logic [CNT_W-1:0]          fifo_count,
  output logic                      overflow
`ifdef SW_EVENT_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]     drop_count
`endif
);

  localparam int unsigned EVT_W = evt_width(IDX_W);

  logic                      primed;
  logic [no_of_switches-1:0] sw_prev;
  logic [no_of_switches-1:0] pending;
  logic [no_of_switches-1:0] change_c;
  logic [no_of_switches-1:0] served_c;
  logic [no_of_switches-1:0] coalesce_c;
  logic [IDX_W-1:0]          sel_idx_c;
  logic                      sel_hit_c;
  logic                      push_c;
  logic [EVT_W-1:0]          push_data_c;
  logic [EVT_W-1:0]          head;
  logic                      fifo_full;
  logic                      fifo_empty;

  assign change_c = primed ? (sw_in ^ sw_prev) : '0;

  // Lowest pending index wins.
  always_comb begin
    sel_idx_c = '0;
    sel_hit_c = 1'b0;
    for (int i = int'(no_of_switches) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx_c = IDX_W'(i);
        sel_hit_c = 1'b1;
      end
    end
  end

  assign push_c = sel_hit_c & ~fifo_full;

  always_comb begin
    served_c = '0;
    if (push_c) served_c[sel_idx_c] = 1'b1;
  end

  assign push_data_c = {sel_idx_c, sw_prev[sel_idx_c]};
  assign coalesce_c  = change_c & pending & ~served_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      primed   <= 1'b0;
      sw_prev  <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else if (!primed) begin
      // Capture the power-up positions without reporting them as changes.
      primed  <= 1'b1;
      sw_prev <= sw_in;
    end else begin
      sw_prev <= sw_in;
      pending <= (pending & ~served_c) | change_c;
      if (|coalesce_c) overflow <= 1'b1;
    end
  end

`ifdef SW_EVENT_DROP_CNT_EN
  localparam int unsigned SUM_W = DROP_CNT_W + 1;

  logic [SUM_W-1:0] drop_sum_c;

  // One count per coalesced bit, clamped at the counter maximum.
  always_comb begin
    drop_sum_c = SUM_W'(drop_count);
    for (int i = 0; i < int'(no_of_switches); i++) begin
      drop_sum_c = drop_sum_c + SUM_W'(coalesce_c[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop_sum_c[DROP_CNT_W]) begin
      drop_count <= '1;
    end else begin
      drop_count <= drop_sum_c[DROP_CNT_W-1:0];
    end
  end
`endif

  sw_event_fifo #(
    .width (EVT_W),
    .depth (fifo_depth)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_c),
    .push_data (push_data_c),
    .full      (fifo_full),
    .pop       (evt_ready),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_index = head[EVT_W-1:EVT_INDEX_LSB];
  assign evt_level = head[EVT_LEVEL_BIT];

endmodule
